// File: rtl/fpga_board_pkg.sv
// Shared types for the board status controller.
//   rst_state_e  : system reset sequencer states
//   exit_state_e : exit-report handshake states
//   led_mode_e   : per-LED drive mode (2 bits per LED on led_mode_i)
//   stretch_w()  : width of the reset stretch counter for a given stretch length
package fpga_board_pkg;

  typedef enum logic [0:0] {
    RstHold = 1'b0,
    RstRun  = 1'b1
  } rst_state_e;

  typedef enum logic [1:0] {
    ExitIdle   = 2'd0,
    ExitReport = 2'd1,
    ExitDrain  = 2'd2
  } exit_state_e;

  typedef enum logic [1:0] {
    LedOff    = 2'b00,
    LedOn     = 2'b01,
    LedBlink  = 2'b10,
    LedStatus = 2'b11
  } led_mode_e;

  // Counter width able to hold 0..rst_stretch.
  function automatic int unsigned stretch_w(input int unsigned rst_stretch);
    return $clog2(rst_stretch + 1);
  endfunction

  // Stretch counter width for the default 16-cycle stretch.
  localparam int unsigned STRETCH_W = stretch_w(16);

endpackage

// File: rtl/fpga_board_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads RESET_VAL into every stage
//   d_i    : asynchronous input
//   q_o    : synchronised output, STAGES cycles of latency
module fpga_board_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_board_status_ctrl.sv
// Board-level control between the FPGA wrapper and x_heep_system.
//   clk_gen         : system clock
//   rst_n           : board reset, asynchronous, active-low
//   ps_rst_ni       : PS reset request (async domain, active-low)
//   ps_ack_i        : PS acknowledge of the exit report (async domain, level)
//   exit_valid_i    : exit_valid from the core
//   exit_value_i    : exit_value from the core
//   led_mode_i      : 2-bit mode per LED, LED k uses [2k+1:2k]
//   sys_rst_no      : stretched core reset, active-low
//   heartbeat_o     : heartbeat counter MSB
//   ps_exit_valid_o : exit report pending for the PS
//   ps_exit_value_o : latched (sticky) exit value
//   led_o           : registered LED drives
module fpga_board_status_ctrl
  import fpga_board_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned RST_STRETCH = 16,
  parameter int unsigned EXIT_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_gen,
  input  logic                  rst_n,
  input  logic                  ps_rst_ni,
  input  logic                  ps_ack_i,
  input  logic                  exit_valid_i,
  input  logic [EXIT_W-1:0]     exit_value_i,
  input  logic [2*NUM_LEDS-1:0] led_mode_i,
  output logic                  sys_rst_no,
  output logic                  heartbeat_o,
  output logic                  ps_exit_valid_o,
  output logic [EXIT_W-1:0]     ps_exit_value_o,
  output logic [NUM_LEDS-1:0]   led_o
);

  localparam int unsigned StretchW = stretch_w(RST_STRETCH);
  localparam logic [StretchW-1:0] StretchMax = StretchW'(RST_STRETCH - 1);

  // Synchronisers: the reset request idles high, the ack idles low.
  logic ps_rst_sync;
  logic ps_ack_sync;

  fpga_board_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_ps_rst (
    .clk_i  (clk_gen),
    .rst_ni (rst_n),
    .d_i    (ps_rst_ni),
    .q_o    (ps_rst_sync)
  );

  fpga_board_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_ps_ack (
    .clk_i  (clk_gen),
    .rst_ni (rst_n),
    .d_i    (ps_ack_i),
    .q_o    (ps_ack_sync)
  );

  // Heartbeat counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Reset sequencer
  rst_state_e          rst_state_q, rst_state_d;
  logic [StretchW-1:0] stretch_q, stretch_d;
  logic                sys_rst_q, sys_rst_d;

  always_comb begin
    rst_state_d = rst_state_q;
    stretch_d   = stretch_q;
    sys_rst_d   = sys_rst_q;
    unique case (rst_state_q)
      RstHold: begin
        sys_rst_d = 1'b0;
        if (!ps_rst_sync) begin
          stretch_d = '0;
        end else if (stretch_q == StretchMax) begin
          // Counter stays at its maximum while running.
          rst_state_d = RstRun;
          sys_rst_d   = 1'b1;
        end else begin
          stretch_d = stretch_q + StretchW'(1);
        end
      end
      RstRun: begin
        if (!ps_rst_sync) begin
          rst_state_d = RstHold;
          sys_rst_d   = 1'b0;
          stretch_d   = '0;
        end
      end
      default: begin
        rst_state_d = RstHold;
        sys_rst_d   = 1'b0;
        stretch_d   = '0;
      end
    endcase
  end

  // Exit report handshake; only rst_n clears it so the PS can read it after a core reset.
  exit_state_e       exit_state_q, exit_state_d;
  logic              exit_valid_q, exit_valid_d;
  logic [EXIT_W-1:0] exit_value_q, exit_value_d;
  logic              captured_q, captured_d;
  logic              ack_prev_q;
  logic              ack_rise;

  assign ack_rise = ps_ack_sync & ~ack_prev_q;

  always_comb begin
    exit_state_d = exit_state_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    captured_d   = captured_q;
    unique case (exit_state_q)
      ExitIdle: begin
        if (exit_valid_i) begin
          exit_value_d = exit_value_i;
          exit_valid_d = 1'b1;
          captured_d   = 1'b1;
          exit_state_d = ExitReport;
        end
      end
      ExitReport: begin
        // Later exit_valid_i pulses are ignored; the first value is sticky.
        if (ack_rise) begin
          exit_valid_d = 1'b0;
          exit_state_d = ExitDrain;
        end
      end
      ExitDrain: begin
        if (!exit_valid_i && !ps_ack_sync) begin
          exit_state_d = ExitIdle;
        end
      end
      default: begin
        exit_state_d = ExitIdle;
        exit_valid_d = 1'b0;
      end
    endcase
  end

  // LED mux. A captured value with bit 0 set is a failure and blinks 4x faster.
  logic                status_led;
  logic [NUM_LEDS-1:0] led_q, led_d;

  assign status_led = captured_q & (exit_value_q[0] ? cnt_q[CNT_W-3] : 1'b1);

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      unique case (led_mode_e'(led_mode_i[2*k +: 2]))
        LedOff:    led_d[k] = 1'b0;
        LedOn:     led_d[k] = 1'b1;
        LedBlink:  led_d[k] = cnt_q[CNT_W-1];
        LedStatus: led_d[k] = status_led;
        default:   led_d[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rst_state_q  <= RstHold;
      stretch_q    <= '0;
      sys_rst_q    <= 1'b0;
      exit_state_q <= ExitIdle;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      captured_q   <= 1'b0;
      ack_prev_q   <= 1'b0;
      led_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      rst_state_q  <= rst_state_d;
      stretch_q    <= stretch_d;
      sys_rst_q    <= sys_rst_d;
      exit_state_q <= exit_state_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      captured_q   <= captured_d;
      ack_prev_q   <= ps_ack_sync;
      led_q        <= led_d;
    end
  end

  assign sys_rst_no      = sys_rst_q;
  assign heartbeat_o     = cnt_q[CNT_W-1];
  assign ps_exit_valid_o = exit_valid_q;
  assign ps_exit_value_o = exit_value_q;
  assign led_o           = led_q;

endmodule

// File: tb/tb_fpga_board_status_ctrl.sv
// Self-checking bench for fpga_board_status_ctrl (CNT_W=4 so blink periods are short).
module tb_fpga_board_status_ctrl;

  localparam int unsigned NumLeds    = 4;
  localparam int unsigned CntW       = 4;
  localparam int unsigned RstStretch = 16;
  localparam int unsigned ExitW      = 32;
  localparam int unsigned SyncStages = 2;

  logic                 clk_gen = 1'b0;
  logic                 rst_n;
  logic                 ps_rst_ni;
  logic                 ps_ack_i;
  logic                 exit_valid_i;
  logic [ExitW-1:0]     exit_value_i;
  logic [2*NumLeds-1:0] led_mode_i;
  logic                 sys_rst_no;
  logic                 heartbeat_o;
  logic                 ps_exit_valid_o;
  logic [ExitW-1:0]     ps_exit_value_o;
  logic [NumLeds-1:0]   led_o;

  fpga_board_status_ctrl #(
    .NUM_LEDS    (NumLeds),
    .CNT_W       (CntW),
    .RST_STRETCH (RstStretch),
    .EXIT_W      (ExitW),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk_gen         (clk_gen),
    .rst_n           (rst_n),
    .ps_rst_ni       (ps_rst_ni),
    .ps_ack_i        (ps_ack_i),
    .exit_valid_i    (exit_valid_i),
    .exit_value_i    (exit_value_i),
    .led_mode_i      (led_mode_i),
    .sys_rst_no      (sys_rst_no),
    .heartbeat_o     (heartbeat_o),
    .ps_exit_valid_o (ps_exit_valid_o),
    .ps_exit_value_o (ps_exit_value_o),
    .led_o           (led_o)
  );

  always #5 clk_gen = ~clk_gen;

  int n_chk  = 0;
  int n_fail = 0;

  // Edges seen since rst_n released; equals the DUT heartbeat count.
  int cyc;
  always @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected exit values pushed on capture stimulus, popped when valid rises.
  logic [ExitW-1:0] exp_q[$];
  logic             prev_valid = 1'b0;

  always @(negedge clk_gen) begin
    if (rst_n && ps_exit_valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL report_unexpected: got value 0x%0h, expected no report", ps_exit_value_o);
      end else begin
        check("report_value", 64'(ps_exit_value_o), 64'(exp_q.pop_front()));
      end
    end
    prev_valid <= ps_exit_valid_o;
  end

  // Count clock cycles until the selected output reaches lvl (bounded).
  task automatic edges_until(input int sel, input logic lvl, output int edges);
    edges = 0;
    while (((sel == 0) ? sys_rst_no : ps_exit_valid_o) !== lvl && edges < 200) begin
      @(negedge clk_gen);
      edges++;
    end
  endtask

  function automatic logic [NumLeds-1:0] led_model(input logic [7:0] mode, input int n,
                                                   input bit cap, input bit v0);
    logic [3:0]         c;
    logic [1:0]         m;
    logic [NumLeds-1:0] r;
    c = 4'(n - 1);  // counter value on the edge that loaded the LEDs
    r = '0;
    for (int k = 0; k < NumLeds; k++) begin
      m = mode[2*k +: 2];
      case (m)
        2'b00:   r[k] = 1'b0;
        2'b01:   r[k] = 1'b1;
        2'b10:   r[k] = c[3];
        default: r[k] = cap ? (v0 ? c[1] : 1'b1) : 1'b0;
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [7:0] mode;
    string      name;
  } led_vec_t;

  led_vec_t led_tab[6];

  task automatic run_led_table(input bit cap, input bit v0);
    logic [3:0] hb_cnt;
    for (int i = 0; i < 6; i++) begin
      led_mode_i = led_tab[i].mode;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk_gen);
        check(led_tab[i].name, 64'(led_o), 64'(led_model(led_tab[i].mode, cyc, cap, v0)));
        hb_cnt = 4'(cyc);
        check("heartbeat", 64'(heartbeat_o), 64'(hb_cnt[3]));
      end
    end
  endtask

  int e;

  initial begin
    led_tab[0] = '{8'h00, "led_all_off"};
    led_tab[1] = '{8'h55, "led_all_on"};
    led_tab[2] = '{8'hAA, "led_all_blink"};
    led_tab[3] = '{8'hFF, "led_all_status"};
    led_tab[4] = '{8'h1B, "led_mix_a"};
    led_tab[5] = '{8'hE4, "led_mix_b"};

    rst_n        = 1'b0;
    ps_rst_ni    = 1'b1;
    ps_ack_i     = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    led_mode_i   = 8'h55;
    repeat (3) @(negedge clk_gen);

    // Reset state
    check("rst_sys_rst_no", 64'(sys_rst_no), 64'd0);
    check("rst_heartbeat", 64'(heartbeat_o), 64'd0);
    check("rst_exit_valid", 64'(ps_exit_valid_o), 64'd0);
    check("rst_exit_value", 64'(ps_exit_value_o), 64'd0);
    check("rst_led", 64'(led_o), 64'd0);

    // Stretch after board reset release
    rst_n = 1'b1;
    edges_until(0, 1'b1, e);
    check("stretch_after_rst_n", 64'(e), 64'(RstStretch));

    // LED modes before any capture: status LEDs stay dark
    run_led_table(1'b0, 1'b0);

    // PS reset pulse in RUN
    ps_rst_ni = 1'b0;
    edges_until(0, 1'b0, e);
    check("ps_rst_fall_latency", 64'(e), 64'(SyncStages + 1));
    ps_rst_ni = 1'b1;
    edges_until(0, 1'b1, e);
    check("ps_rst_release_stretch", 64'(e), 64'(SyncStages + RstStretch));

    // Second pulse mid-HOLD restarts the stretch
    ps_rst_ni = 1'b0;
    edges_until(0, 1'b0, e);
    check("ps_rst_fall_latency2", 64'(e), 64'(SyncStages + 1));
    ps_rst_ni = 1'b1;
    repeat (8) @(negedge clk_gen);
    ps_rst_ni = 1'b0;
    repeat (3) @(negedge clk_gen);
    check("hold_still_low", 64'(sys_rst_no), 64'd0);
    ps_rst_ni = 1'b1;
    edges_until(0, 1'b1, e);
    check("hold_restart_stretch", 64'(e), 64'(SyncStages + RstStretch));

    // Exit capture: first value sticky
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0000;
    exp_q.push_back(32'h0000_0000);
    @(negedge clk_gen);
    check("capture0_valid", 64'(ps_exit_valid_o), 64'd1);
    exit_value_i = 32'h0000_0001;
    @(negedge clk_gen);
    exit_valid_i = 1'b0;
    led_mode_i   = 8'hFF;
    @(negedge clk_gen);
    check("sticky_value", 64'(ps_exit_value_o), 64'd0);
    check("sticky_valid", 64'(ps_exit_valid_o), 64'd1);
    check("status_pass_led", 64'(led_o), 64'hF);

    // Ack clears valid after the synchroniser plus edge detect
    ps_ack_i = 1'b1;
    edges_until(1, 1'b0, e);
    check("ack_clear_latency", 64'(e), 64'(SyncStages + 1));
    check("value_held_after_ack", 64'(ps_exit_value_o), 64'd0);

    // DRAIN holds while exit_valid_i stays high
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0ABC;
    ps_ack_i     = 1'b0;
    repeat (6) @(negedge clk_gen);
    check("drain_no_capture_valid", 64'(ps_exit_valid_o), 64'd0);
    check("drain_no_capture_value", 64'(ps_exit_value_o), 64'd0);
    exit_valid_i = 1'b0;
    repeat (3) @(negedge clk_gen);

    // Back in IDLE: capture a failing value
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0001;
    exp_q.push_back(32'h0000_0001);
    @(negedge clk_gen);
    exit_valid_i = 1'b0;
    check("capture1_valid", 64'(ps_exit_valid_o), 64'd1);
    check("capture1_value", 64'(ps_exit_value_o), 64'd1);

    // Core reset does not touch the exit latch; fail status blinks fast
    ps_rst_ni = 1'b0;
    edges_until(0, 1'b0, e);
    check("ps_rst_fall_latency3", 64'(e), 64'(SyncStages + 1));
    run_led_table(1'b1, 1'b1);
    check("latch_survives_ps_rst", 64'(ps_exit_value_o), 64'd1);
    check("valid_survives_ps_rst", 64'(ps_exit_valid_o), 64'd1);
    check("sys_rst_held_low", 64'(sys_rst_no), 64'd0);

    // Asynchronous board reset mid-REPORT
    led_mode_i = 8'h55;
    @(negedge clk_gen);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sys_rst_no", 64'(sys_rst_no), 64'd0);
    check("async_heartbeat", 64'(heartbeat_o), 64'd0);
    check("async_exit_valid", 64'(ps_exit_valid_o), 64'd0);
    check("async_exit_value", 64'(ps_exit_value_o), 64'd0);
    check("async_led", 64'(led_o), 64'd0);
    ps_rst_ni  = 1'b1;
    led_mode_i = 8'hFF;
    @(negedge clk_gen);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk_gen);
      check("status_dark_after_rst", 64'(led_o), 64'd0);
    end
    edges_until(0, 1'b1, e);
    check("stretch_after_rst_n2", 64'(e), 64'(RstStretch - 5));

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
